fpu_op_sequencer: RTL and testbench

Initiator-side front end for the single-precision ALU. Accepts one floating-point command at a time over a valid/ready interface and drives the ALU's operation select and A/B operands. It holds them stable for that operation's fixed latency, then captures the 32-bit result and the compare flags. The result, flags and echoed tag go back to the requester over a valid/ready response interface with backpressure.

---
 rtl/fpu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: single-issue front end for the SP ALU.
// Holds operands for the op latency, then returns result/flags.
module fpu_op_sequencer #(
  parameter int unsigned LAT_ADD = 4,
  parameter int unsigned LAT_SUB = 4,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 8,
  parameter int unsigned LAT_CMP = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_operation,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_equal,
  input  logic             alu_greater,
  input  logic             alu_lesser,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_equal,
  output logic             rsp_greater,
  output logic             rsp_lesser,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [2:0] OP_NONE = 3'b111;
  localparam logic [2:0] OP_CMP  = 3'd4;

  if (LAT_ADD < 1 || LAT_ADD > 255 ||
      LAT_SUB < 1 || LAT_SUB > 255 ||
      LAT_MUL < 1 || LAT_MUL > 255 ||
      LAT_DIV < 1 || LAT_DIV > 255 ||
      LAT_CMP < 1 || LAT_CMP > 255) begin : g_bad_lat
    $error("fpu_op_sequencer: LAT_* must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic             legal;
  logic [7:0]       lat_sel;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Decode op legality and its fixed latency
  always_comb begin
    legal   = 1'b1;
    lat_sel = 8'd1;
    case (cmd_op)
      3'd0:    lat_sel = 8'(LAT_ADD);
      3'd1:    lat_sel = 8'(LAT_SUB);
      3'd2:    lat_sel = 8'(LAT_MUL);
      3'd3:    lat_sel = 8'(LAT_DIV);
      3'd4:    lat_sel = 8'(LAT_CMP);
      default: legal   = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nxt = legal ? WAIT : RESP;
      WAIT: if (cnt == 8'd1) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand drive, latency count and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 8'd0;
      tag_q         <= '0;
      alu_operation <= OP_NONE;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'd0;
      rsp_equal     <= 1'b0;
      rsp_greater   <= 1'b0;
      rsp_lesser    <= 1'b0;
      rsp_tag       <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      unique case (state)
        IDLE: begin
          if (cmd_valid && legal) begin
            alu_operation <= cmd_op;
            alu_a         <= cmd_a;
            alu_b         <= cmd_b;
            tag_q         <= cmd_tag;
            cnt           <= lat_sel;
          end else if (cmd_valid) begin
            rsp_err     <= 1'b1;
            rsp_data    <= 32'd0;
            rsp_equal   <= 1'b0;
            rsp_greater <= 1'b0;
            rsp_lesser  <= 1'b0;
            rsp_tag     <= cmd_tag;
          end
        end
        WAIT: begin
          if (cnt == 8'd1) begin
            rsp_err       <= 1'b0;
            rsp_tag       <= tag_q;
            alu_operation <= OP_NONE;
            if (alu_operation == OP_CMP) begin
              rsp_data    <= 32'd0;
              rsp_equal   <= alu_equal;
              rsp_greater <= alu_greater;
              rsp_lesser  <= alu_lesser;
            end else begin
              rsp_data    <= alu_out;
              rsp_equal   <= 1'b0;
              rsp_greater <= 1'b0;
              rsp_lesser  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed bench with a latency-aware ALU model.
// Operands must be stable for the op latency before alu_out is valid.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_a = 32'd0;
  logic [31:0] cmd_b = 32'd0;
  logic [3:0]  cmd_tag = 4'd0;
  logic [2:0]  alu_operation;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_equal;
  logic        alu_greater;
  logic        alu_lesser;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_equal;
  logic        rsp_greater;
  logic        rsp_lesser;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  fpu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_tag(cmd_tag),
    .alu_operation(alu_operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_equal(alu_equal), .alu_greater(alu_greater),
    .alu_lesser(alu_lesser),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_equal(rsp_equal),
    .rsp_greater(rsp_greater), .rsp_lesser(rsp_lesser),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 4;
      3'd2:       return 3;
      3'd3:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] alu_fn(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0 && a == 32'h3FC00000 && b == 32'h40100000)
      return 32'h40700000;
    if (op == 3'd2 && a == 32'h40000000 && b == 32'h40400000)
      return 32'h40C00000;
    return a ^ b ^ {29'd0, op};
  endfunction

  // ALU model: age counts edges the operands have been held stable
  logic [2:0]  m_op = 3'b111;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  int          age = 0;

  always @(posedge clk) begin
    if (alu_operation != m_op || alu_a != m_a || alu_b != m_b) begin
      m_op <= alu_operation;
      m_a  <= alu_a;
      m_b  <= alu_b;
      age  <= 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign alu_out = (age >= lat_of(alu_operation) - 1)
                 ? alu_fn(alu_operation, alu_a, alu_b)
                 : 32'hBAD0BAD0;
  assign alu_equal = (alu_a == alu_b);
  assign alu_greater = !alu_equal &&
    ((!alu_a[31] && alu_b[31]) ||
     (!alu_a[31] && !alu_b[31] && alu_a > alu_b) ||
     (alu_a[31] && alu_b[31] && alu_a < alu_b));
  assign alu_lesser = !alu_equal && !alu_greater;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_operation, 3'b111);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // Add, latency 4
    rsp_ready = 1'b1;
    issue(3'd0, 32'h3FC00000, 32'h40100000, 4'd3);
    chk("add_alu_op", alu_operation, 3'd0);
    chk("add_alu_a", alu_a, 32'h3FC00000);
    chk("add_alu_b", alu_b, 32'h40100000);
    chk("add_cmd_ready", cmd_ready, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("add_wait_valid", rsp_valid, 0);
      chk("add_wait_op", alu_operation, 3'd0);
    end
    tick();
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_data", rsp_data, 32'h40700000);
    chk("add_rsp_tag", rsp_tag, 3);
    chk("add_rsp_err", rsp_err, 0);
    chk("add_op_idle", alu_operation, 3'b111);
    tick();
    chk("add_hs_valid", rsp_valid, 0);
    chk("add_hs_ready", cmd_ready, 1);
    chk("add_hs_data_kept", rsp_data, 32'h40700000);

    // Mul with 5 cycles of backpressure
    rsp_ready = 1'b0;
    issue(3'd2, 32'h40000000, 32'h40400000, 4'd7);
    tick();
    tick();
    chk("mul_early", rsp_valid, 0);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_tag   = 4'd5;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("mul_bp_valid", rsp_valid, 1);
      chk("mul_bp_data", rsp_data, 32'h40C00000);
      chk("mul_bp_tag", rsp_tag, 7);
      chk("mul_bp_cmd_ready", cmd_ready, 0);
      chk("mul_bp_alu_op", alu_operation, 3'b111);
      if (i < 4) tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("mul_hs_valid", rsp_valid, 0);
    chk("mul_hs_busy", busy, 0);

    // Compare equal then lesser
    issue(3'd4, 32'h3F800000, 32'h3F800000, 4'd1);
    chk("cmp_alu_op", alu_operation, 3'd4);
    tick();
    chk("cmpeq_valid", rsp_valid, 1);
    chk("cmpeq_flags", {rsp_equal, rsp_greater, rsp_lesser}, 3'b100);
    chk("cmpeq_data", rsp_data, 0);
    tick();
    issue(3'd4, 32'hBF800000, 32'h3F800000, 4'd2);
    tick();
    chk("cmplt_valid", rsp_valid, 1);
    chk("cmplt_flags", {rsp_equal, rsp_greater, rsp_lesser}, 3'b001);
    chk("cmplt_tag", rsp_tag, 2);
    tick();

    // Illegal op
    issue(3'd6, 32'h12345678, 32'h9ABCDEF0, 4'd9);
    chk("ill_valid", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_tag", rsp_tag, 9);
    chk("ill_data", rsp_data, 0);
    chk("ill_flags", {rsp_equal, rsp_greater, rsp_lesser}, 3'b000);
    chk("ill_alu_op", alu_operation, 3'b111);
    tick();
    chk("ill_hs_valid", rsp_valid, 0);
    chk("ill_hs_alu_op", alu_operation, 3'b111);

    // Reset mid-divide
    issue(3'd3, 32'h00000001, 32'h00000002, 4'd2);
    chk("div_alu_op", alu_operation, 3'd3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("divrst_busy", busy, 0);
    chk("divrst_valid", rsp_valid, 0);
    chk("divrst_alu_op", alu_operation, 3'b111);
    chk("divrst_alu_a", alu_a, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("divrst_no_rsp", rsp_valid, 0);
    end
    issue(3'd0, 32'h00000005, 32'h00000003, 4'd4);
    tick();
    tick();
    tick();
    chk("post_early", rsp_valid, 0);
    tick();
    chk("post_valid", rsp_valid, 1);
    chk("post_data", rsp_data, 32'h00000006);
    chk("post_tag", rsp_tag, 4);
    tick();

    // Back-to-back adds, rsp_ready held high
    cmd_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cmd_op  = 3'd0;
      cmd_a   = 32'h100 * (n + 1);
      cmd_b   = n;
      cmd_tag = 4'(10 + n);
      chk("b2b_ready", cmd_ready, 1);
      tick();
      chk("b2b_busy", busy, 1);
      cmd_tag = 4'd15;
      cmd_a   = 32'hFFFFFFFF;
      tick();
      tick();
      tick();
      chk("b2b_early", rsp_valid, 0);
      tick();
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_tag", rsp_tag, 10 + n);
      chk("b2b_data", rsp_data, (32'h100 * (n + 1)) ^ n);
      tick();
      chk("b2b_one_cycle", rsp_valid, 0);
    end
    cmd_valid = 1'b0;
    tick();
    chk("end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
